// File: rtl/kmap_sweep_checker.sv
// Truth-table sweeper for 4-input Boolean blocks: walks all 16 minterms,
// samples f after a settle delay and checks it against a masked expected table.
module kmap_sweep_checker #(
  parameter int unsigned SETTLE = 0
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic [15:0] care_mask,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic        mismatch
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] care_q, care_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  err_q, err_d;
  logic [3:0]  first_q, first_d;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      care_q  <= '0;
      table_q <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      care_q  <= care_d;
      table_q <= table_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    care_d  = care_q;
    table_d = table_q;
    err_d   = err_q;
    first_d = first_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = expected;
          care_d  = care_mask;
          table_d = '0;
          err_d   = '0;
          first_d = '0;
          idx_d   = '0;
          cnt_d   = SETTLE_L;
          state_d = (SETTLE_L == 4'd0) ? S_SAMPLE : S_WAIT;
        end
      end
      S_WAIT: begin
        // Leaving on the decrement to zero keeps WAIT exactly SETTLE cycles long.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        table_d[idx_q] = f;
        if (care_q[idx_q] && (f != exp_q[idx_q])) begin
          err_d = err_q + 5'd1;
          if (err_q == 5'd0) first_d = idx_q;
        end
        if (idx_q == 4'd15) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = SETTLE_L;
          state_d = (SETTLE_L == 4'd0) ? S_SAMPLE : S_WAIT;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WAIT) || (state_q == S_SAMPLE);
    done = (state_q == S_FINISH);
    {a, b, c, d} = busy ? idx_q : 4'd0;
  end

  assign table_out     = table_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign mismatch      = (err_q != 5'd0);

endmodule

// File: tb/tb_kmap_sweep_checker.sv
// Bench for kmap_sweep_checker: a SETTLE=0 instance with a combinational model
// and a SETTLE=3 instance whose model output is delayed by three registers.
module tb_kmap_sweep_checker;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start3 = 1'b0;
  logic [15:0] expected = '0, care_mask = '0;
  logic [15:0] tbl0 = '0, tbl3 = '0;

  logic        a0, b0, c0, d0, f0, busy0, done0, mism0;
  logic [15:0] table0;
  logic [4:0]  err0;
  logic [3:0]  first0;
  logic        a3, b3, c3, d3, f3, busy3, done3, mism3;
  logic [15:0] table3;
  logic [4:0]  err3;
  logic [3:0]  first3;
  logic        r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;

  assign f0 = tbl0[{a0, b0, c0, d0}];
  always @(posedge clk) begin
    r1 <= tbl3[{a3, b3, c3, d3}];
    r2 <= r1;
    r3 <= r2;
  end
  assign f3 = r3;

  kmap_sweep_checker #(.SETTLE(0)) dut0 (
    .clk(clk), .areset_n(areset_n), .start(start0), .expected(expected),
    .care_mask(care_mask), .a(a0), .b(b0), .c(c0), .d(d0), .f(f0),
    .busy(busy0), .done(done0), .table_out(table0), .err_count(err0),
    .first_err_idx(first0), .mismatch(mism0)
  );

  kmap_sweep_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .areset_n(areset_n), .start(start3), .expected(expected),
    .care_mask(care_mask), .a(a3), .b(b3), .c(c3), .d(d3), .f(f3),
    .busy(busy3), .done(done3), .table_out(table3), .err_count(err3),
    .first_err_idx(first3), .mismatch(mism3)
  );

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  err;
    logic [3:0]  first;
  } res_t;

  res_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic test_reset();
    areset_n = 1'b0;
    start0 = 1'b1;
    start3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tbl0 = ~tbl0;
      tbl3 = ~tbl3;
      checks++;
      if ({a0, b0, c0, d0, busy0, done0, table0, err0, first0, mism0} !== 32'd0) begin
        errors++;
        $display("FAIL reset_dut0: got %h want 0",
                 {a0, b0, c0, d0, busy0, done0, table0, err0, first0, mism0});
      end
      checks++;
      if ({a3, b3, c3, d3, busy3, done3, table3, err3, first3, mism3} !== 32'd0) begin
        errors++;
        $display("FAIL reset_dut3: got %h want 0",
                 {a3, b3, c3, d3, busy3, done3, table3, err3, first3, mism3});
      end
    end
    start0 = 1'b0;
    start3 = 1'b0;
    @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy0, done0, busy3, done3} !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b want 0000", {busy0, done0, busy3, done3});
    end
  endtask

  task automatic pop_compare0(input string name);
    res_t r;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_done: got done with empty scoreboard want none", name);
    end else begin
      r = sb_q.pop_front();
      checks++;
      if (table0 !== r.tbl) begin
        errors++;
        $display("FAIL %s_table: got %h want %h", name, table0, r.tbl);
      end
      checks++;
      if (err0 !== r.err) begin
        errors++;
        $display("FAIL %s_err_count: got %0d want %0d", name, err0, r.err);
      end
      checks++;
      if (first0 !== r.first) begin
        errors++;
        $display("FAIL %s_first_err_idx: got %0d want %0d", name, first0, r.first);
      end
      checks++;
      if (mism0 !== (r.err != 5'd0)) begin
        errors++;
        $display("FAIL %s_mismatch: got %b want %b", name, mism0, (r.err != 5'd0));
      end
    end
  endtask

  // Called at a negedge; one full SETTLE=0 sweep with drive, timing and result checks.
  task automatic run_sweep0(input string name, input logic [15:0] model,
                            input logic [15:0] exp_t, input logic [15:0] care,
                            input logic [15:0] want_tbl, input logic [4:0] want_err,
                            input logic [3:0] want_first);
    res_t r;
    int done_cyc;
    tbl0 = model;
    expected = exp_t;
    care_mask = care;
    r.tbl = want_tbl;
    r.err = want_err;
    r.first = want_first;
    sb_q.push_back(r);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 30 && done_cyc == 0; cyc++) begin
      if (cyc <= 16) begin
        checks++;
        if ({a0, b0, c0, d0} !== 4'(cyc - 1) || busy0 !== 1'b1) begin
          errors++;
          $display("FAIL %s_drive_c%0d: got idx %0d busy %b want idx %0d busy 1",
                   name, cyc, {a0, b0, c0, d0}, busy0, cyc - 1);
        end
      end
      if (done0 === 1'b1) begin
        done_cyc = cyc;
        checks++;
        if (busy0 !== 1'b0 || {a0, b0, c0, d0} !== 4'd0) begin
          errors++;
          $display("FAIL %s_finish_outputs: got busy %b idx %0d want busy 0 idx 0",
                   name, busy0, {a0, b0, c0, d0});
        end
        pop_compare0(name);
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (done_cyc != 17) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d want 17", name, done_cyc);
    end
    @(negedge clk);
    checks++;
    if (table0 !== want_tbl || err0 !== want_err || done0 !== 1'b0) begin
      errors++;
      $display("FAIL %s_hold: got table %h err %0d done %b want table %h err %0d done 0",
               name, table0, err0, done0, want_tbl, want_err);
    end
  endtask

  task automatic test_clean();
    run_sweep0("clean", 16'hDD0C, 16'hDD0C, 16'hDDEF, 16'hDD0C, 5'd0, 4'd0);
  endtask

  task automatic test_dont_care();
    run_sweep0("dont_care", 16'hFF1C, 16'hDD0C, 16'hDDEF, 16'hFF1C, 5'd0, 4'd0);
  endtask

  task automatic test_errors();
    run_sweep0("errors", 16'hD52C, 16'hDD0C, 16'hDDEF, 16'hD52C, 5'd2, 4'd5);
    run_sweep0("all_err", 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 5'd16, 4'd0);
    run_sweep0("last_err", 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 5'd1, 4'd15);
  endtask

  task automatic test_settle();
    res_t r;
    int done_seen;
    tbl3 = 16'hDD0C;
    expected = 16'hDD0C;
    care_mask = 16'hDDEF;
    r.tbl = 16'hDD0C;
    r.err = 5'd0;
    r.first = 4'd0;
    sb_q.push_back(r);
    done_seen = 0;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      checks++;
      if (busy3 !== (cyc <= 64) || done3 !== (cyc == 65)) begin
        errors++;
        $display("FAIL settle_ctrl_c%0d: got busy %b done %b want busy %b done %b",
                 cyc, busy3, done3, (cyc <= 64), (cyc == 65));
      end
      if (cyc <= 64) begin
        checks++;
        if ({a3, b3, c3, d3} !== 4'((cyc - 1) / 4)) begin
          errors++;
          $display("FAIL settle_drive_c%0d: got %0d want %0d", cyc, {a3, b3, c3, d3},
                   (cyc - 1) / 4);
        end
      end
      if (done3 === 1'b1 && sb_q.size() != 0) begin
        done_seen = 1;
        r = sb_q.pop_front();
        checks++;
        if (table3 !== r.tbl || err3 !== r.err || first3 !== r.first || mism3 !== 1'b0) begin
          errors++;
          $display("FAIL settle_result: got table %h err %0d first %0d mism %b want %h %0d %0d 0",
                   table3, err3, first3, mism3, r.tbl, r.err, r.first);
        end
      end
      start3 = (cyc == 20);
      @(negedge clk);
    end
    start3 = 1'b0;
    checks++;
    if (done_seen != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL settle_done_seen: got %0d pending %0d want 1 pending 0", done_seen,
               sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    tbl0 = 16'hDD0C;
    expected = 16'hDD0C;
    care_mask = 16'hDDEF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if ({a0, b0, c0, d0} !== 4'd7) begin
      errors++;
      $display("FAIL reset_mid_idx: got %0d want 7", {a0, b0, c0, d0});
    end
    #1 areset_n = 1'b0;
    #1;
    checks++;
    if ({a0, b0, c0, d0, busy0, done0, table0, err0, first0, mism0} !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h want 0",
               {a0, b0, c0, d0, busy0, done0, table0, err0, first0, mism0});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got done %b busy %b want 0 0", done0, busy0);
    end
    areset_n = 1'b1;
    @(negedge clk);
    run_sweep0("after_reset", 16'hDD0C, 16'hDD0C, 16'hDDEF, 16'hDD0C, 5'd0, 4'd0);
  endtask

  task automatic test_back_to_back();
    res_t r;
    int dones;
    tbl0 = 16'hDD0C;
    expected = 16'hDD0C;
    care_mask = 16'hDDEF;
    r.tbl = 16'hDD0C; r.err = 5'd0; r.first = 4'd0;
    sb_q.push_back(r);
    r.tbl = 16'hDD0C; r.err = 5'd8; r.first = 4'd2;
    sb_q.push_back(r);
    dones = 0;
    start0 = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 5) expected = 16'h0000;
      checks++;
      if (done0 !== (cyc == 17 || cyc == 35) ||
          busy0 !== ((cyc >= 1 && cyc <= 16) || (cyc >= 19 && cyc <= 34))) begin
        errors++;
        $display("FAIL b2b_ctrl_c%0d: got done %b busy %b", cyc, done0, busy0);
      end
      if (done0 === 1'b1) begin
        dones++;
        pop_compare0("b2b");
      end
      if (cyc == 35) start0 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (dones != 2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d dones pending %0d want 2 pending 0", dones,
               sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_dont_care();
    test_errors();
    test_settle();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
